// File: rtl/log_op_sequencer_pkg.sv
// Shared opcodes and FSM encoding for the int_log command sequencer.
package log_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_NAND = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NOT  = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic is_rsvd(input logic [2:0] op);
        return op == OP_RSVD;
    endfunction

endpackage

// File: rtl/log_op_sequencer_if.sv
// Command and response channels of the sequencer.
// Both channels: a transfer happens on a rising edge where valid && ready; the
// sender holds its payload stable while valid is high and ready is low.
interface log_op_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/log_op_sequencer_cmd_fifo.sv
// Synchronous command FIFO; caller guarantees no push when full, no pop when empty.
module log_cmd_fifo #(
    parameter  int DW    = 35,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/log_op_sequencer.sv
// Buffers logic-op commands, issues them one at a time to int_log, returns results.
module log_op_sequencer
    import log_pkg::*;
#(
    parameter  int WIDTH      = 16,
    parameter  int FIFO_DEPTH = 4,
    parameter  int LOG_LAT    = 1,
    localparam int CW         = $clog2(FIFO_DEPTH + 1),
    localparam int WCW        = $clog2(LOG_LAT + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    log_op_sequencer_if.slave    bus,
    output logic [2:0]           operation,
    output logic [WIDTH-1:0]     opa_log,
    output logic [WIDTH-1:0]     opb_log,
    input  logic [WIDTH-1:0]     out_log,
    output logic                 busy,
    output logic [CW-1:0]        fifo_count,
    output state_t               state
);
    localparam int EW = 3 + 2 * WIDTH;

    logic             ready_q;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic [EW-1:0]    pop_data;
    logic [2:0]       pop_op;
    logic [WIDTH-1:0] pop_a;
    logic [WIDTH-1:0] pop_b;
    logic [WCW-1:0]   wait_cnt;
    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_err_q;

    // ready_q holds cmd_ready low through reset and rises on the first edge after.
    assign bus.cmd_ready = ready_q && !fifo_full;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;

    assign push = bus.cmd_valid && bus.cmd_ready;
    assign pop  = (state == ST_IDLE) && !fifo_empty;
    assign busy = (state != ST_IDLE) || !fifo_empty;

    assign {pop_op, pop_a, pop_b} = pop_data;

    log_cmd_fifo #(
        .DW    (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({bus.cmd_op, bus.cmd_a, bus.cmd_b}),
        .pop       (pop),
        .pop_data  (pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            ready_q     <= 1'b0;
            operation   <= '0;
            opa_log     <= '0;
            opb_log     <= '0;
            wait_cnt    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        // Reserved opcodes never reach the logic unit; its inputs stay put.
                        if (is_rsvd(pop_op)) begin
                            rsp_data_q  <= '0;
                            rsp_err_q   <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state       <= ST_RESP;
                        end else begin
                            operation <= pop_op;
                            opa_log   <= pop_a;
                            opb_log   <= pop_b;
                            wait_cnt  <= WCW'(LOG_LAT);
                            state     <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt - WCW'(1);
                    if (wait_cnt == WCW'(1)) begin
                        rsp_data_q  <= out_log;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_log_op_sequencer.sv
// Directed bench: u_dut1 (LOG_LAT=1) for the main flow, u_dut3 (LOG_LAT=3) for hold/reset cases.
module tb_log_op_sequencer;
    import log_pkg::*;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst1;
    logic rst3;
    always #5 clk = ~clk;

    log_op_sequencer_if #(.WIDTH(W)) b1 ();
    log_op_sequencer_if #(.WIDTH(W)) b3 ();

    logic [2:0]   op1, op3;
    logic [W-1:0] a1, bb1, o1, a3, bb3, o3;
    logic         busy1, busy3;
    logic [2:0]   cnt1, cnt3;
    state_t       st1, st3;

    // Stand-in for the int_log unit: purely combinational.
    function automatic logic [W-1:0] lu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        r = '0;
        case (op)
            OP_AND:  r = a & b;
            OP_NAND: r = ~(a & b);
            OP_OR:   r = a | b;
            OP_NOR:  r = ~(a | b);
            OP_XOR:  r = a ^ b;
            OP_XNOR: r = ~(a ^ b);
            OP_NOT:  r = ~a;
            OP_RSVD: r = '0;
            default: r = '0;
        endcase
        return r;
    endfunction

    assign o1 = lu(op1, a1, bb1);
    assign o3 = lu(op3, a3, bb3);

    log_op_sequencer #(.WIDTH(W), .FIFO_DEPTH(4), .LOG_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst1), .bus(b1.slave), .operation(op1), .opa_log(a1), .opb_log(bb1),
        .out_log(o1), .busy(busy1), .fifo_count(cnt1), .state(st1)
    );

    log_op_sequencer #(.WIDTH(W), .FIFO_DEPTH(4), .LOG_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst3), .bus(b3.slave), .operation(op3), .opa_log(a3), .opb_log(bb3),
        .out_log(o3), .busy(busy3), .fifo_count(cnt3), .state(st3)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard for u_dut1: {err, data} in issue order.
    logic [16:0] exp_q[$];
    int          rsp_seen1 = 0;

    always @(negedge clk) begin
        if (!rst1 && b1.rsp_valid && b1.rsp_ready) begin
            logic [31:0] e;
            rsp_seen1++;
            e = (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'hxxxxxxxx;
            check("rsp1", 32'({b1.rsp_err, b1.rsp_data}), e);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Entered and left at posedge+1; returns just after the accept edge.
    task automatic send1(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic ok;
        ok = 1'b0;
        b1.cmd_valid = 1'b1; b1.cmd_op = op; b1.cmd_a = a; b1.cmd_b = b;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = b1.cmd_ready;
            @(posedge clk);
            #1;
        end
        b1.cmd_valid = 1'b0;
        check("send1_accept", 32'(ok), 32'd1);
    endtask

    task automatic send3(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic ok;
        ok = 1'b0;
        b3.cmd_valid = 1'b1; b3.cmd_op = op; b3.cmd_a = a; b3.cmd_b = b;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = b3.cmd_ready;
            @(posedge clk);
            #1;
        end
        b3.cmd_valid = 1'b0;
        check("send3_accept", 32'(ok), 32'd1);
    endtask

    task automatic drain1();
        int i;
        for (i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && !busy1 && !b1.rsp_valid) break;
            tick(1);
        end
        check("drain1_left", 32'(exp_q.size()), 32'd0);
    endtask

    logic [2:0]   t3_op [6] = '{OP_OR, OP_NOR, OP_XOR, OP_NAND, OP_AND, OP_OR};
    logic [W-1:0] t3_a  [6] = '{16'h00F0, 16'h00F0, 16'h1234, 16'hFFFF, 16'h1234, 16'h0001};
    logic [W-1:0] t3_b  [6] = '{16'h0F00, 16'h0F00, 16'hFFFF, 16'h00FF, 16'h00FF, 16'h0002};
    logic [W-1:0] t3_r  [6] = '{16'h0FF0, 16'hF00F, 16'hEDCB, 16'hFF00, 16'h0034, 16'h0003};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc;
        int base;
        int seen3;
        logic ok;

        rst1 = 1'b1; rst3 = 1'b1;
        b1.cmd_valid = 1'b0; b1.cmd_op = '0; b1.cmd_a = '0; b1.cmd_b = '0; b1.rsp_ready = 1'b0;
        b3.cmd_valid = 1'b0; b3.cmd_op = '0; b3.cmd_a = '0; b3.cmd_b = '0; b3.rsp_ready = 1'b0;
        tick(2);

        check("rst_cmd_ready", 32'(b1.cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(b1.rsp_valid), 32'd0);
        check("rst_fifo_count", 32'(cnt1), 32'd0);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_state", 32'(st1), 32'(ST_IDLE));
        check("rst_outputs", 32'({op1, a1, b1.rsp_data}), 32'd0);

        rst1 = 1'b0; rst3 = 1'b0;
        tick(1);
        check("rel_cmd_ready", 32'(b1.cmd_ready), 32'd1);

        // Test 1: AND, latency two cycles after accept.
        b1.rsp_ready = 1'b1;
        exp_q.push_back({1'b0, 16'hF000});
        send1(OP_AND, 16'hF0F0, 16'hFF00);
        check("t1_valid_n", 32'(b1.rsp_valid), 32'd0);
        tick(1);
        check("t1_valid_n1", 32'(b1.rsp_valid), 32'd0);
        tick(1);
        check("t1_valid_n2", 32'(b1.rsp_valid), 32'd1);
        check("t1_data", 32'(b1.rsp_data), 32'h0000F000);
        drain1();

        // Test 2: NOT and XNOR.
        exp_q.push_back({1'b0, 16'hFF00});
        send1(OP_NOT, 16'h00FF, 16'h1234);
        exp_q.push_back({1'b0, 16'h0000});
        send1(OP_XNOR, 16'hAAAA, 16'h5555);
        drain1();

        // Test 3: backpressure fills one in flight plus four buffered.
        b1.rsp_ready = 1'b0;
        base = rsp_seen1;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            b1.cmd_valid = 1'b1; b1.cmd_op = t3_op[acc]; b1.cmd_a = t3_a[acc]; b1.cmd_b = t3_b[acc];
            @(negedge clk);
            ok = b1.cmd_ready;
            if (ok) exp_q.push_back({1'b0, t3_r[acc]});
            @(posedge clk);
            #1;
            if (ok) acc++;
        end
        b1.cmd_valid = 1'b0;
        check("t3_accepted", 32'(acc), 32'd5);
        check("t3_cmd_ready", 32'(b1.cmd_ready), 32'd0);
        check("t3_fifo_count", 32'(cnt1), 32'd4);
        check("t3_busy", 32'(busy1), 32'd1);
        b1.rsp_ready = 1'b1;
        drain1();
        check("t3_rsp_count", 32'(rsp_seen1 - base), 32'd5);

        // Test 4: reserved opcode traps without touching the logic-unit inputs.
        exp_q.push_back({1'b1, 16'h0000});
        send1(OP_RSVD, 16'hFFFF, 16'h0000);
        check("t4_valid_n", 32'(b1.rsp_valid), 32'd0);
        tick(1);
        check("t4_valid_n1", 32'(b1.rsp_valid), 32'd1);
        check("t4_err", 32'(b1.rsp_err), 32'd1);
        drain1();
        check("t4_operands_kept", 32'({op1, a1}), 32'({OP_AND, 16'h1234}));
        check("t4_opb_kept", 32'(bb1), 32'h000000FF);
        exp_q.push_back({1'b0, 16'h1200});
        send1(OP_AND, 16'h1234, 16'hFF00);
        drain1();

        // Test 5 (LOG_LAT=3): operands hold through WAIT, response holds under backpressure.
        b3.rsp_ready = 1'b0;
        send3(OP_AND, 16'hF0F0, 16'hFF00);
        send3(OP_NOR, 16'h0000, 16'h0000);
        b3.cmd_a = 16'h5A5A; b3.cmd_b = 16'hA5A5;
        for (int k = 0; k < 3; k++) begin
            check("t5_wait_state", 32'(st3), 32'(ST_WAIT));
            check("t5_opa_hold", 32'(a3), 32'h0000F0F0);
            check("t5_opb_hold", 32'(bb3), 32'h0000FF00);
            tick(1);
        end
        for (int k = 0; k < 10; k++) begin
            check("t5_rsp_hold", 32'({b3.rsp_valid, b3.rsp_err, b3.rsp_data}), 32'({1'b1, 1'b0, 16'hF000}));
            tick(1);
        end
        b3.rsp_ready = 1'b1;
        tick(1);
        check("t5_valid_drop", 32'(b3.rsp_valid), 32'd0);
        for (int k = 0; k < 20 && !b3.rsp_valid; k++) tick(1);
        check("t5_second", 32'({b3.rsp_valid, b3.rsp_err, b3.rsp_data}), 32'({1'b1, 1'b0, 16'hFFFF}));
        tick(1);
        for (int k = 0; k < 20 && busy3; k++) tick(1);
        check("t5_idle", 32'(busy3), 32'd0);

        // Test 6: reset in WAIT with three queued discards everything.
        b3.rsp_ready = 1'b0;
        send3(OP_OR,  16'h0001, 16'h0002);
        send3(OP_XOR, 16'h0003, 16'h0004);
        send3(OP_AND, 16'h0005, 16'h0006);
        send3(OP_NOT, 16'h0007, 16'h0008);
        check("t6_pre_state", 32'(st3), 32'(ST_WAIT));
        check("t6_pre_count", 32'(cnt3), 32'd3);
        #2 rst3 = 1'b1;
        #1;
        check("t6_rst_valid", 32'(b3.rsp_valid), 32'd0);
        check("t6_rst_count", 32'(cnt3), 32'd0);
        check("t6_rst_busy", 32'(busy3), 32'd0);
        check("t6_rst_ready", 32'(b3.cmd_ready), 32'd0);
        tick(1);
        check("t6_rst_state", 32'(st3), 32'(ST_IDLE));
        rst3 = 1'b0;
        b3.rsp_ready = 1'b1;
        tick(1);
        check("t6_rel_ready", 32'(b3.cmd_ready), 32'd1);
        seen3 = 0;
        for (int k = 0; k < 20; k++) begin
            if (b3.rsp_valid) seen3++;
            tick(1);
        end
        check("t6_no_rsp", 32'(seen3), 32'd0);
        check("t6_still_idle", 32'({busy3, cnt3}), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
